// File: rtl/sample_stream_tx_pkg.sv
// Shared definitions for the sample stream transmitter: sample width,
// default timing/depth, and the IDLE/RUN state encoding.
package sample_stream_tx_pkg;

   // Width of one IF sample as seen by the channel top.
   localparam int INPUT_W          = 12;

   // Default clk cycles per clk_sample half-period and default FIFO depth.
   localparam int DEF_HALF_PERIOD  = 8;
   localparam int DEF_DEPTH        = 16;

   // Width of the phase counter; covers 2*255-1.
   localparam int PHASE_W          = 9;

   typedef enum logic {
      STX_IDLE = 1'b0,
      STX_RUN  = 1'b1
   } stx_state_e;

endpackage

// File: rtl/sample_stream_tx_fifo.sv
// Synchronous single-clock FIFO with registered full/empty/count.
// A push into a full FIFO is still accepted when a pop happens in the same
// cycle. Storage has no reset; only pointers and flags are cleared.
module sample_fifo
   import sample_stream_tx_pkg::*;
#(
   parameter int WIDTH = INPUT_W + 1,
   parameter int DEPTH = DEF_DEPTH,
   parameter int CW    = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty,
   output logic [CW-1:0]    count
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             full_q, full_d;
   logic             empty_q, empty_d;
   logic             do_push;
   logic             do_pop;

   // Next pointer/occupancy state; a pop frees the slot a same-cycle push needs.
   always_comb begin
      do_pop   = pop && !empty_q;
      do_push  = push && (!full_q || do_pop);
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (do_push && !do_pop)      count_d = count_q + CW'(1);
      else if (do_pop && !do_push) count_d = count_q - CW'(1);
      full_d   = (count_d == CW'(DEPTH));
      empty_d  = (count_d == '0);
   end

   // Control state register.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         full_q   <= 1'b0;
         empty_q  <= 1'b1;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         full_q   <= full_d;
         empty_q  <= empty_d;
      end
   end

   // Sample storage write port.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= din;
   end

   assign dout  = mem_q[rd_ptr_q];
   assign full  = full_q;
   assign empty = empty_q;
   assign count = count_q;

endmodule

// File: rtl/sample_stream_tx.sv
// Emulated ADC front end: buffers host samples and replays them on a divided
// sample clock, changing data only at the falling-edge boundary (phase 0) so
// each sample is stable HALF_PERIOD cycles either side of the rising edge.
module sample_stream_tx
   import sample_stream_tx_pkg::*;
#(
   parameter int HALF_PERIOD = DEF_HALF_PERIOD,
   parameter int DEPTH       = DEF_DEPTH,
   parameter int CW          = $clog2(DEPTH) + 1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               en,
   input  logic               wr_en,
   input  logic [INPUT_W-1:0] wr_data,
   input  logic               wr_valid,
   output logic               fifo_full,
   output logic [CW-1:0]      fifo_count,
   output logic               overflow,
   output logic               clk_sample,
   output logic               sample_valid,
   output logic [INPUT_W-1:0] data,
   output logic [31:0]        samples_sent,
   output logic [15:0]        underrun_count
);

   localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(2 * HALF_PERIOD - 1);
   localparam logic [PHASE_W-1:0] PHASE_HIGH = PHASE_W'(HALF_PERIOD);

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   stx_state_e         state_q, state_d;
   logic [PHASE_W-1:0] phase_q, phase_d;
   logic [PHASE_W-1:0] phase_inc;
   logic               clk_sample_q, clk_sample_d;
   logic               sample_valid_q, sample_valid_d;
   logic [INPUT_W-1:0] data_q, data_d;
   logic [31:0]        samples_sent_q, samples_sent_d;
   logic [15:0]        underrun_q, underrun_d;
   logic               overflow_q, overflow_d;
   logic               load;
   logic               pop;
   logic               fifo_empty;
   logic [INPUT_W:0]   fifo_dout;

   sample_fifo #(
      .WIDTH (INPUT_W + 1),
      .DEPTH (DEPTH),
      .CW    (CW)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (wr_en),
      .din   ({wr_valid, wr_data}),
      .pop   (pop),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   // Period sequencing, sample loading and statistics.
   always_comb begin
      state_d        = state_q;
      phase_d        = phase_q;
      clk_sample_d   = clk_sample_q;
      sample_valid_d = sample_valid_q;
      data_d         = data_q;
      samples_sent_d = samples_sent_q;
      underrun_d     = underrun_q;
      load           = 1'b0;
      pop            = 1'b0;
      phase_inc      = phase_q + PHASE_W'(1);

      // Dropped writes: FIFO full and no pop frees a slot this cycle.
      overflow_d = overflow_q | (wr_en & fifo_full & ~(pop_possible(state_q, phase_q, en, fifo_empty)));

      case (state_q)
         STX_IDLE: begin
            clk_sample_d   = 1'b0;
            sample_valid_d = 1'b0;
            phase_d        = '0;
            if (en) begin
               state_d = STX_RUN;
               load    = 1'b1;
            end
         end
         default: begin
            if (phase_q == PHASE_LAST) begin
               phase_d      = '0;
               clk_sample_d = 1'b0;
               if (en) begin
                  load = 1'b1;
               end else begin
                  state_d        = STX_IDLE;
                  sample_valid_d = 1'b0;
               end
            end else begin
               phase_d      = phase_inc;
               clk_sample_d = (phase_inc >= PHASE_HIGH);
            end
         end
      endcase

      // A load presents the next queued sample, or records an underrun.
      if (load) begin
         if (!fifo_empty) begin
            pop            = 1'b1;
            data_d         = fifo_dout[INPUT_W-1:0];
            sample_valid_d = fifo_dout[INPUT_W];
            if (fifo_dout[INPUT_W]) samples_sent_d = samples_sent_q + 32'd1;
         end else begin
            sample_valid_d = 1'b0;
            underrun_d     = sat_inc16(underrun_q);
         end
      end
   end

   // True when a load will pop the FIFO this cycle.
   function automatic logic pop_possible(input stx_state_e st, input logic [PHASE_W-1:0] ph,
                                         input logic req, input logic emp);
      return req && !emp && ((st == STX_IDLE) || (ph == PHASE_LAST));
   endfunction

   // State and output registers; reset clears everything mid-period too.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= STX_IDLE;
         phase_q        <= '0;
         clk_sample_q   <= 1'b0;
         sample_valid_q <= 1'b0;
         data_q         <= '0;
         samples_sent_q <= '0;
         underrun_q     <= '0;
         overflow_q     <= 1'b0;
      end else begin
         state_q        <= state_d;
         phase_q        <= phase_d;
         clk_sample_q   <= clk_sample_d;
         sample_valid_q <= sample_valid_d;
         data_q         <= data_d;
         samples_sent_q <= samples_sent_d;
         underrun_q     <= underrun_d;
         overflow_q     <= overflow_d;
      end
   end

   assign overflow       = overflow_q;
   assign clk_sample     = clk_sample_q;
   assign sample_valid   = sample_valid_q;
   assign data           = data_q;
   assign samples_sent   = samples_sent_q;
   assign underrun_count = underrun_q;

endmodule
